// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam int ADDR_LSB = 2;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] instr;
   } imem_rsp_t;
endpackage

// File: rtl/instr_mem_responder_fifo.sv
// Synchronous response FIFO (imem_rsp_fifo) holding imem_rsp_t entries.
module imem_rsp_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      i_push,
   input  imem_rsp_t i_data,
   input  logic      i_pop,
   output imem_rsp_t o_data,
   output logic      o_full,
   output logic      o_empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   imem_rsp_t     r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= nxt(r_wptr);
         if (w_pop)  r_rptr <= nxt(r_rptr);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
      end
   end

   // Credits upstream make a push into a full FIFO impossible.
   always_ff @(posedge clk_i) begin
      if (!rst_i) assert (!(i_push && o_full));
   end
endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side instruction memory: credit-limited request intake, fixed-latency
// RAM read pipeline and an in-order response FIFO.
module instr_mem_responder
   import imem_pkg::*;
#(
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter     INIT_FILE  = ""
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_instr_o,
   output logic        rsp_err_o,
   input  logic        ld_we_i,
   input  logic [31:0] ld_addr_i,
   input  logic [31:0] ld_data_i
);
   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0]              r_mem [MEM_WORDS];
   logic [XLEN-1:0]              r_ram_q;
   logic [LATENCY:1]             r_vld, r_err;
   logic [LATENCY:0]             w_vld_nxt, w_err_nxt;
   logic [LATENCY:1][XLEN-1:0]   w_dat;
   logic [OW-1:0]                r_out;
   logic [XLEN-ADDR_LSB-1:0]     w_idx;
   logic                         w_req_err, w_acc, w_pop, w_ld_ok;
   logic                         w_full, w_empty;
   imem_rsp_t                    w_push_rsp, w_head;

   // Full 30-bit index compare so high addresses are flagged, never aliased.
   assign w_idx     = req_addr_i[XLEN-1:ADDR_LSB];
   assign w_req_err = (req_addr_i[ADDR_LSB-1:0] != '0) || ({2'b00, w_idx} >= 32'(MEM_WORDS));
   assign w_ld_ok   = ld_we_i && (ld_addr_i < 32'(MEM_WORDS));

   assign req_ready_o = !rst_i && (r_out < OW'(FIFO_DEPTH));
   assign w_acc       = req_valid_i && req_ready_o;
   assign w_pop       = rsp_valid_o && rsp_ready_i;

   // Non-blocking write beside the read gives read-first on a same-word collision.
   always_ff @(posedge clk_i) begin
      if (w_ld_ok) r_mem[ld_addr_i[AW-1:0]] <= ld_data_i;
      r_ram_q <= r_mem[w_idx[AW-1:0]];
   end

   assign w_vld_nxt = {r_vld, w_acc};
   assign w_err_nxt = {r_err, w_req_err};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vld <= '0;
         r_err <= '0;
         r_out <= '0;
      end else begin
         r_vld <= w_vld_nxt[LATENCY-1:0];
         r_err <= w_err_nxt[LATENCY-1:0];
         if (w_acc && !w_pop)      r_out <= r_out + OW'(1);
         else if (!w_acc && w_pop) r_out <= r_out - OW'(1);
      end
   end

   assign w_dat[1] = r_ram_q;
   for (genvar k = 2; k <= LATENCY; k++) begin : g_dstage
      logic [XLEN-1:0] r_d;
      always_ff @(posedge clk_i) r_d <= w_dat[k-1];
      assign w_dat[k] = r_d;
   end

   assign w_push_rsp.err   = r_err[LATENCY];
   assign w_push_rsp.instr = r_err[LATENCY] ? NOP_INSTR : w_dat[LATENCY];

   imem_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (r_vld[LATENCY]),
      .i_data  (w_push_rsp),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign rsp_valid_o = !w_empty;
   assign rsp_instr_o = w_empty ? '0 : w_head.instr;
   assign rsp_err_o   = !w_empty && w_head.err;

   logic w_unused;
   assign w_unused = w_full;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed vectors plus scoreboarded random traffic for instr_mem_responder.
module tb_instr_mem_responder;
   localparam int MEM_WORDS  = 1024;
   localparam int LATENCY    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, rsp_ready = 1'b0, ld_we = 1'b0;
   logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_instr;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   instr_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_instr_o(rsp_instr), .rsp_err_o(rsp_err),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Scoreboard with a shadow memory; expected data is captured before the
   // same-cycle loader write lands (read-first).
   typedef struct packed { logic err; logic [31:0] instr; } exp_t;
   exp_t        sbq[$];
   exp_t        sb_e;
   logic [31:0] shadow [MEM_WORDS];
   int          tb_out = 0;

   function automatic exp_t model(input logic [31:0] a);
      exp_t e;
      if (a[1:0] != 2'b00 || {2'b00, a[31:2]} >= 32'(MEM_WORDS)) begin
         e.err = 1'b1; e.instr = NOP;
      end else begin
         e.err = 1'b0; e.instr = shadow[a[11:2]];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         tb_out = 0;
      end else begin
         chk("ready_credit", {63'd0, req_ready}, {63'd0, tb_out < FIFO_DEPTH});
         chk("outstanding_bound", 64'(tb_out <= FIFO_DEPTH), 64'd1);
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) chk("sb_unexpected_rsp", 64'd1, 64'd0);
            else begin
               sb_e = sbq.pop_front();
               chk("sb_err", {63'd0, rsp_err}, {63'd0, sb_e.err});
               chk("sb_instr", {32'd0, rsp_instr}, {32'd0, sb_e.instr});
            end
            tb_out--;
         end
         if (req_valid && req_ready) begin
            sbq.push_back(model(req_addr));
            tb_out++;
         end
         if (ld_we && ld_addr < 32'(MEM_WORDS)) shadow[ld_addr[9:0]] = ld_data;
      end
   end

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_we = 1'b0;
   endtask

   // One request (optionally alongside a loader write), then a bounded wait.
   task automatic one_req(input logic [31:0] a, input logic w, input logic [31:0] wa,
                          input logic [31:0] wd, output logic got, output logic e,
                          output logic [31:0] d);
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = a;
      ld_we = w; ld_addr = wa; ld_data = wd;
      tick();
      req_valid = 1'b0; ld_we = 1'b0;
      got = 1'b0; e = 1'b0; d = '0;
      for (int n = 0; n < 10 && !got; n++) begin
         if (rsp_valid) begin got = 1'b1; e = rsp_err; d = rsp_instr; end
         else tick();
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   typedef struct { logic [31:0] addr; logic err; logic [31:0] instr; } vec_t;
   vec_t vecs [8];

   initial begin
      logic        got, e;
      logic [31:0] d;
      int          acc, n;

      vecs[0] = '{32'h0000_0006,              1'b1, NOP};
      vecs[1] = '{32'(4*MEM_WORDS),           1'b1, NOP};
      vecs[2] = '{32'(4*MEM_WORDS-4),         1'b0, 32'hCAFE_F00D};
      vecs[3] = '{32'h0000_001C,              1'b0, 32'hA000_0007};
      vecs[4] = '{32'h0000_0001,              1'b1, NOP};
      vecs[5] = '{32'hFFFF_FFFC,              1'b1, NOP};
      vecs[6] = '{32'h4000_0000,              1'b1, NOP};
      vecs[7] = '{32'h0000_0000,              1'b0, 32'hA000_0000};

      // Reset state
      #1;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_instr", {32'd0, rsp_instr}, 64'd0);
      chk("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
      tick(); tick();
      rst = 1'b0; #1;
      chk("release_ready", {63'd0, req_ready}, 64'd1);

      for (int i = 0; i < 8; i++) load(32'(i), 32'hA000_0000 + 32'(i));
      load(32'(MEM_WORDS-1), 32'hCAFE_F00D);

      // Streaming: first response visible after edge N+LATENCY, then one per cycle
      rsp_ready = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         req_valid = (c < 8); req_addr = 32'(4*c);
         if (c < 8) chk("stream_ready", {63'd0, req_ready}, 64'd1);
         tick();
         if (c >= LATENCY && c < LATENCY + 8) begin
            chk("stream_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stream_instr", {32'd0, rsp_instr}, {32'd0, 32'hA000_0000 + 32'(c-LATENCY)});
         end else chk("stream_idle", {63'd0, rsp_valid}, 64'd0);
      end
      req_valid = 1'b0;

      // Backpressure: only FIFO_DEPTH accepted out of 6 offered
      rsp_ready = 1'b0; acc = 0;
      for (int k = 0; k < 6; k++) begin
         req_valid = 1'b1; req_addr = 32'(4*acc);
         if (req_ready) acc++;
         tick();
      end
      req_valid = 1'b0;
      chk("bp_accepted", 64'(acc), 64'(FIFO_DEPTH));
      chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
      chk("bp_head_stable", {32'd0, rsp_instr}, {32'd0, 32'hA000_0000});
      tick();
      chk("bp_head_held", {32'd0, rsp_instr}, {32'd0, 32'hA000_0000});
      rsp_ready = 1'b1; n = 0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid) n++;
         tick();
      end
      chk("bp_drained", 64'(n), 64'(FIFO_DEPTH));
      rsp_ready = 1'b0;

      // Out-of-range loader write must not alias onto word 0
      load(32'(MEM_WORDS), 32'h0BAD_0BAD);

      for (int v = 0; v < 8; v++) begin
         one_req(vecs[v].addr, 1'b0, '0, '0, got, e, d);
         chk("vec_got",   {63'd0, got}, 64'd1);
         chk("vec_err",   {63'd0, e},   {63'd0, vecs[v].err});
         chk("vec_instr", {32'd0, d},   {32'd0, vecs[v].instr});
      end

      // Read-first collision on word 5
      load(32'd5, 32'h1111_1111);
      one_req(32'h14, 1'b1, 32'd5, 32'hDEAD_BEEF, got, e, d);
      chk("rf_old", {32'd0, d}, {32'd0, 32'h1111_1111});
      one_req(32'h14, 1'b0, '0, '0, got, e, d);
      chk("rf_new", {32'd0, d}, {32'd0, 32'hDEAD_BEEF});

      // Mid-stream reset with 3 outstanding
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1; req_addr = 32'(4*k);
         tick();
      end
      req_valid = 1'b0;
      chk("mr_pre_valid", {63'd0, rsp_valid}, 64'd1);
      rst = 1'b1; #1;
      chk("mr_valid", {63'd0, rsp_valid}, 64'd0);
      chk("mr_ready", {63'd0, req_ready}, 64'd0);
      chk("mr_instr", {32'd0, rsp_instr}, 64'd0);
      tick(); tick();
      rst = 1'b0; rsp_ready = 1'b1; #1;
      chk("mr_release_ready", {63'd0, req_ready}, 64'd1);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid) n++;
         tick();
      end
      chk("mr_no_stale", 64'(n), 64'd0);

      // Random valid/ready traffic against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         int r;
         r = $urandom_range(0, 10);
         req_valid = $urandom_range(0, 1) == 1;
         if (r < 8)       req_addr = 32'(4*r);
         else if (r == 8) req_addr = 32'(4*(MEM_WORDS-1));
         else if (r == 9) req_addr = $urandom | 32'h1;
         else             req_addr = 32'h4000_0000;
         rsp_ready = $urandom_range(0, 1) == 1;
         tick();
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      chk("rand_sb_empty", 64'(sbq.size()), 64'd0);
      chk("rand_out_zero", 64'(tb_out), 64'd0);
      chk("rand_idle", {63'd0, rsp_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
